// File: rtl/c2n_service_mcast_splitter_pkg.sv
// Block-local definitions for the multicast splitter (FSM encoding only).
package c2n_service_mcast_splitter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } splitter_state_t;

endpackage

// File: rtl/npu_message_service_defines.sv
// Shared NPU service-message types used by the c2n scheduler, the splitter and the virtual network.
`ifndef TILE_COUNT
`define TILE_COUNT 8
`endif

package npu_message_service_defines;

    localparam int NUM_TILES     = `TILE_COUNT;
    localparam int TILE_ID_WIDTH = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    typedef logic [NUM_TILES-1:0]     tile_mask_t;
    typedef logic [TILE_ID_WIDTH-1:0] tile_id_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [27:0] address;
        logic [31:0] data;
    } service_message_t;

endpackage

// File: rtl/oh_to_idx.sv
// One-hot to binary index encoder; DIRECTION "LSB0" numbers bit 0 as index 0.
module oh_to_idx #(
    parameter int    NUM_SIGNALS = 4,
    parameter string DIRECTION   = "LSB0",
    parameter int    INDEX_WIDTH = $clog2(NUM_SIGNALS)
) (
    input  logic [NUM_SIGNALS-1:0] one_hot,
    output logic [INDEX_WIDTH-1:0] index
);

    // OR of the indices of all set bits: exact for a true one-hot input.
    always_comb begin
        index = '0;
        for (int i = 0; i < NUM_SIGNALS; i++) begin
            if (one_hot[i]) begin
                if (DIRECTION == "LSB0") begin
                    index = index | INDEX_WIDTH'(i);
                end else begin
                    index = index | INDEX_WIDTH'(NUM_SIGNALS - 1 - i);
                end
            end
        end
    end

endmodule

// File: rtl/c2n_service_mcast_splitter.sv
// Splits one multicast service message into ascending-index unicast packets for the virtual network.
`ifndef TILE_COUNT
`define TILE_COUNT 8
`endif

module c2n_service_mcast_splitter
    import npu_message_service_defines::*;
    import c2n_service_mcast_splitter_pkg::*;
#(
    parameter int TILE_COUNT = `TILE_COUNT,
    parameter int TILE_ID_W  = $clog2(TILE_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  service_message_t      message_in,
    input  logic                  message_in_valid,
    input  logic [TILE_COUNT-1:0] destination_valid_in,
    output logic                  network_available_out,
    output service_message_t      message_out,
    output logic                  message_out_valid,
    output logic [TILE_ID_W-1:0]  destination_out,
    input  logic                  network_available,
    output logic                  drop_zero_mask,
    output splitter_state_t       debug_state
);

    // Handshakes: upstream accept = message_in_valid && network_available_out;
    // downstream transfer = message_out_valid && network_available. Outputs
    // hold steady while valid is high and the network is not accepting.

    splitter_state_t       state_q;
    service_message_t      msg_q;
    logic [TILE_COUNT-1:0] pending_q;
    logic [TILE_COUNT-1:0] lowest_bit;
    logic [TILE_COUNT-1:0] pending_next;
    logic                  single_pending;
    logic                  accept;
    logic                  accept_load;
    logic                  transfer;

    assign lowest_bit     = pending_q & (-pending_q);
    assign single_pending = (pending_q != '0) && (pending_q == lowest_bit);

    // A new message may only enter once the final destination is leaving this cycle.
    assign network_available_out = (state_q == IDLE) || (single_pending && network_available);

    assign message_out_valid = (state_q == SEND);
    assign message_out       = msg_q;
    assign debug_state       = state_q;

    assign transfer    = message_out_valid && network_available;
    assign accept      = message_in_valid && network_available_out;
    assign accept_load = accept && (destination_valid_in != '0);

    assign pending_next = transfer ? (pending_q & ~lowest_bit) : pending_q;

    oh_to_idx #(
        .NUM_SIGNALS (TILE_COUNT),
        .DIRECTION   ("LSB0"),
        .INDEX_WIDTH (TILE_ID_W)
    ) u_lowest_idx (
        .one_hot (lowest_bit),
        .index   (destination_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            msg_q          <= '0;
            pending_q      <= '0;
            drop_zero_mask <= 1'b0;
        end else begin
            drop_zero_mask <= accept && (destination_valid_in == '0);
            if (accept_load) begin
                msg_q     <= message_in;
                pending_q <= destination_valid_in;
                state_q   <= SEND;
            end else begin
                // Zero-mask acceptance lands here too: nothing loads and the FSM drains to IDLE.
                pending_q <= pending_next;
                if (pending_next == '0) begin
                    state_q <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_c2n_service_mcast_splitter.sv
// Directed table-driven bench for the multicast splitter at TILE_COUNT=8.
module tb_c2n_service_mcast_splitter;
    import npu_message_service_defines::*;
    import c2n_service_mcast_splitter_pkg::*;

    localparam int TC = 8;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             reset;
    service_message_t message_in;
    logic             message_in_valid;
    logic [TC-1:0]    destination_valid_in;
    logic             network_available_out;
    service_message_t message_out;
    logic             message_out_valid;
    logic [IW-1:0]    destination_out;
    logic             network_available;
    logic             drop_zero_mask;
    splitter_state_t  debug_state;

    c2n_service_mcast_splitter #(
        .TILE_COUNT (TC),
        .TILE_ID_W  (IW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .message_in            (message_in),
        .message_in_valid      (message_in_valid),
        .destination_valid_in  (destination_valid_in),
        .network_available_out (network_available_out),
        .message_out           (message_out),
        .message_out_valid     (message_out_valid),
        .destination_out       (destination_out),
        .network_available     (network_available),
        .drop_zero_mask        (drop_zero_mask),
        .debug_state           (debug_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             in_valid;
        logic [TC-1:0]    mask;
        service_message_t msg;
        logic             net_av;
        logic             exp_nao;
        logic             exp_mov;
        logic [IW-1:0]    exp_dest;
        service_message_t exp_msg;
        logic             exp_drop;
    } vec_t;

    vec_t           vecs[$];
    logic [IW-1:0]  exp_q[$];
    int             n_applied     = 0;
    int             n_miscompares = 0;

    service_message_t msg_a, msg_b, msg_c, msg_d, msg_z;

    function automatic service_message_t mk_msg(logic [3:0] op, logic [27:0] addr, logic [31:0] data);
        service_message_t m;
        m.opcode  = op;
        m.address = addr;
        m.data    = data;
        return m;
    endfunction

    // scoreboard compare
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input string name, input logic v, input logic [TC-1:0] m,
                                input service_message_t msg, input logic nav, input logic nao,
                                input logic mov, input logic [IW-1:0] d, input service_message_t em,
                                input logic drop);
        vec_t x;
        x.name = name;     x.in_valid = v;   x.mask = m;     x.msg = msg;
        x.net_av = nav;    x.exp_nao = nao;  x.exp_mov = mov; x.exp_dest = d;
        x.exp_msg = em;    x.exp_drop = drop;
        vecs.push_back(x);
    endfunction

    // driver: called at a negedge; inputs settle, outputs checked, then one clock edge
    task automatic apply_vec(input vec_t v);
        message_in_valid     = v.in_valid;
        destination_valid_in = v.mask;
        message_in           = v.msg;
        network_available    = v.net_av;
        #2;
        check({v.name, ".nao"},   64'(network_available_out), 64'(v.exp_nao));
        check({v.name, ".valid"}, 64'(message_out_valid),     64'(v.exp_mov));
        check({v.name, ".drop"},  64'(drop_zero_mask),        64'(v.exp_drop));
        check({v.name, ".state"}, 64'(debug_state),           64'(v.exp_mov ? SEND : IDLE));
        if (v.exp_mov) begin
            check({v.name, ".dest"}, 64'(destination_out), 64'(v.exp_dest));
            check({v.name, ".msg"},  64'(message_out),     64'(v.exp_msg));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        message_in_valid     = 1'b0;
        destination_valid_in = '0;
        message_in           = '0;
        network_available    = 1'b1;
    endtask

    initial begin
        msg_a = mk_msg(4'h1, 28'h000_0123, 32'hA5A5_0001);
        msg_b = mk_msg(4'h2, 28'h0AB_CDEF, 32'h5A5A_0002);
        msg_c = mk_msg(4'h3, 28'hFFF_FFFF, 32'hDEAD_BEEF);
        msg_d = mk_msg(4'hC, 28'h123_4567, 32'h0BAD_F00D);
        msg_z = '0;

        // three-destination mask, network always ready
        add("m26_acc",  1, 8'h26, msg_a, 1,  1, 0, 0, msg_z, 0);
        add("m26_d1",   0, 8'h00, msg_z, 1,  0, 1, 1, msg_a, 0);
        add("m26_d2",   0, 8'h00, msg_z, 1,  0, 1, 2, msg_a, 0);
        add("m26_d5",   0, 8'h00, msg_z, 1,  1, 1, 5, msg_a, 0);
        add("m26_idle", 0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 0);
        // stall with the first destination pending, then top bit without wrap
        add("m81_acc",   1, 8'h81, msg_b, 1,  1, 0, 0, msg_z, 0);
        add("m81_hold0", 0, 8'h00, msg_z, 0,  0, 1, 0, msg_b, 0);
        add("m81_hold1", 0, 8'h00, msg_z, 0,  0, 1, 0, msg_b, 0);
        add("m81_hold2", 0, 8'h00, msg_z, 0,  0, 1, 0, msg_b, 0);
        add("m81_d0",    0, 8'h00, msg_z, 1,  0, 1, 0, msg_b, 0);
        add("m81_d7",    0, 8'h00, msg_z, 1,  1, 1, 7, msg_b, 0);
        add("m81_idle",  0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 0);
        // back-to-back: B held on the input early must be ignored until the last A bit
        add("b2b_accA",    1, 8'h03, msg_c, 1,  1, 0, 0, msg_z, 0);
        add("b2b_A0_ign",  1, 8'h10, msg_d, 1,  0, 1, 0, msg_c, 0);
        add("b2b_A1_accB", 1, 8'h10, msg_d, 1,  1, 1, 1, msg_c, 0);
        add("b2b_B4",      0, 8'h00, msg_z, 1,  1, 1, 4, msg_d, 0);
        add("b2b_idle",    0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 0);
        // zero mask from IDLE
        add("zero_acc",   1, 8'h00, msg_a, 1,  1, 0, 0, msg_z, 0);
        add("zero_drop",  0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 1);
        add("zero_quiet", 0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 0);
        // zero mask accepted alongside the last-bit transfer
        add("last_acc",     1, 8'h40, msg_b, 1,  1, 0, 0, msg_z, 0);
        add("last_d6_zero", 1, 8'h00, msg_c, 1,  1, 1, 6, msg_b, 0);
        add("last_drop",    0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 1);
        add("last_quiet",   0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 0);
        // single pending bit but network busy: upstream must be refused
        add("hold_acc",     1, 8'h08, msg_a, 1,  1, 0, 0, msg_z, 0);
        add("hold_d3_nav0", 1, 8'h01, msg_b, 0,  0, 1, 3, msg_a, 0);
        add("hold_d3_nav1", 0, 8'h00, msg_z, 1,  1, 1, 3, msg_a, 0);
        add("hold_idle",    0, 8'h00, msg_z, 1,  1, 0, 0, msg_z, 0);

        idle_inputs();
        reset = 1'b1;
        #1;
        check("reset.valid", 64'(message_out_valid),     64'(0));
        check("reset.nao",   64'(network_available_out), 64'(1));
        check("reset.drop",  64'(drop_zero_mask),        64'(0));
        check("reset.state", 64'(debug_state),           64'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i]);
        end

        // full mask, reset after two transfers
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd1);
        message_in_valid     = 1'b1;
        destination_valid_in = 8'hFF;
        message_in           = msg_d;
        network_available    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            #2;
            check("ff.valid", 64'(message_out_valid), 64'(1));
            check("ff.dest",  64'(destination_out),   64'(exp_q.pop_front()));
            check("ff.msg",   64'(message_out),       64'(msg_d));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        reset = 1'b1;
        #1;
        check("ff_rst.valid", 64'(message_out_valid),     64'(0));
        check("ff_rst.nao",   64'(network_available_out), 64'(1));
        check("ff_rst.state", 64'(debug_state),           64'(IDLE));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("ff_post.valid", 64'(message_out_valid), 64'(0));
            check("ff_post.drop",  64'(drop_zero_mask),    64'(0));
            @(posedge clk);
            @(negedge clk);
        end
        message_in_valid     = 1'b1;
        destination_valid_in = 8'h04;
        message_in           = msg_c;
        #2;
        check("ff_new.nao", 64'(network_available_out), 64'(1));
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        #2;
        check("ff_new.valid", 64'(message_out_valid), 64'(1));
        check("ff_new.dest",  64'(destination_out),   64'(2));
        check("ff_new.msg",   64'(message_out),       64'(msg_c));
        @(posedge clk);
        @(negedge clk);
        #2;
        check("ff_new.idle", 64'(message_out_valid), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule

// File: doc/c2n_service_mcast_splitter.md
C2N_SERVICE_MCAST_SPLITTER -- requirements
Module: c2n_service_mcast_splitter

Interface
REQ-001 SHALL have parameter TILE_COUNT, default `TILE_COUNT, number of tiles and width of the destination mask.
REQ-002 SHALL have parameter TILE_ID_W, default $clog2(TILE_COUNT), width of the unicast destination index.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 message_in  input  service_message_t  service message from the c2n scheduler.
REQ-006 message_in_valid  input  1  message_in and destination_valid_in carry a message this cycle.
REQ-007 destination_valid_in  input  TILE_COUNT  multicast tile mask for message_in.
REQ-008 network_available_out  output  1  splitter accepts a message this cycle; drives the scheduler's network_available.
REQ-009 message_out  output  service_message_t  latched message presented to the virtual network.
REQ-010 message_out_valid  output  1  one unicast packet is offered this cycle.
REQ-011 destination_out  output  TILE_ID_W  tile index of the offered packet.
REQ-012 network_available  input  1  virtual network accepts the offered packet this cycle.
REQ-013 drop_zero_mask  output  1  one-cycle pulse: an accepted message had an all-zero mask.

Function
REQ-014 SHALL implement FSM {IDLE, SEND}, with registers msg_q (service_message_t) and pending_q (TILE_COUNT bits).
REQ-015 Transfer on the network side SHALL mean message_out_valid && network_available in the same cycle.
REQ-016 network_available_out SHALL be 1 in IDLE, and 1 in SEND only when pending_q has exactly one bit set and network_available=1; otherwise 0.
REQ-017 Upstream acceptance SHALL mean message_in_valid && network_available_out; message_in_valid while network_available_out=0 SHALL be ignored (upstream never does this).
REQ-018 On acceptance with destination_valid_in != 0: msg_q <= message_in, pending_q <= destination_valid_in, next state SEND.
REQ-019 On acceptance with destination_valid_in == 0: message discarded, drop_zero_mask=1 next cycle, state becomes or remains IDLE.
REQ-020 In SEND, message_out_valid SHALL be 1, message_out=msg_q, destination_out=index of the lowest set bit of pending_q.
REQ-021 In IDLE, message_out_valid SHALL be 0; message_out and destination_out are don't-care.
REQ-022 On each transfer the lowest set bit of pending_q SHALL clear; if it was the last bit and no new message is accepted, next state SHALL be IDLE.
REQ-023 Last-bit transfer coinciding with a new acceptance SHALL load the new message and stay in SEND, giving back-to-back operation with no bubble.
REQ-024 message_out and destination_out SHALL stay stable while message_out_valid=1 and network_available=0.
REQ-025 Latency from acceptance to first message_out_valid SHALL be 1 cycle; an N-bit mask SHALL take at least N cycles to drain.
REQ-026 Destinations SHALL be issued in ascending tile index; bit TILE_COUNT-1 SHALL be valid and must not wrap.

Reset
REQ-027 Reset SHALL immediately force state=IDLE, pending_q=0, msg_q=0, message_out_valid=0, drop_zero_mask=0, network_available_out=1 after release.
REQ-028 Reset asserted mid-SEND SHALL discard the remaining destinations with no further packets.

Structure
REQ-029 service_message_t, tile_mask_t and the tile-index type SHALL come from the shared npu_message_service_defines package; this block declares no new shared types.
REQ-030 Lowest-bit isolation (pending_q & -pending_q) SHALL feed the existing oh_to_idx (DIRECTION "LSB0") sub-module; no other sub-module.

Verification (TILE_COUNT=8)
REQ-031 Mask 8'b0010_0110, network_available=1 -> destinations 1,2,5 on three consecutive cycles, then IDLE; network_available_out=1 only in the third cycle.
REQ-032 Mask 8'b1000_0001, network_available low for 3 cycles -> destination_out=0 held stable for 3 cycles, then 0 and 7 issued.
REQ-033 Two messages A (8'b0000_0011) and B (8'b0001_0000) back-to-back -> A@0, A@1, B@4 on consecutive cycles with no bubble.
REQ-034 Mask 8'h00 -> no message_out_valid; drop_zero_mask pulses once; state stays IDLE.
REQ-035 Mask 8'hFF, reset asserted after two transfers -> message_out_valid drops at once; no further packets; accepts a new message after reset release.
